// File: rtl/sha512_compression.sv
// Iterative SHA-512 compression core: load a..h, then one round per clock for ROUNDS rounds.
// Optional macro SHA512_FEEDFORWARD_EN adds the initial values back in on the final round.
module sha512_compression #(
   parameter int ROUNDS = 80
) (
   input  logic        clk,
   input  logic        sha512_reset,
   input  logic [63:0] wi,
   input  logic [63:0] ki,
   input  logic [63:0] ai,
   input  logic [63:0] bi,
   input  logic [63:0] ci,
   input  logic [63:0] di,
   input  logic [63:0] ei,
   input  logic [63:0] fi,
   input  logic [63:0] gi,
   input  logic [63:0] hi,
   output logic [63:0] oa,
   output logic [63:0] ob,
   output logic [63:0] oc,
   output logic [63:0] od,
   output logic [63:0] oe,
   output logic [63:0] of,
   output logic [63:0] og,
   output logic [63:0] oh,
   output logic        sha512_done
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

   state_t      state_q;
   logic [6:0]  t_q;
   logic        done_q;
   logic [63:0] v_q   [8];
   logic [63:0] init_v[8];
   logic [63:0] rnd_d [8];
   logic [63:0] fin_d [8];
   logic [63:0] s1, ch, t1, s0, maj, t2;

`ifdef SHA512_FEEDFORWARD_EN
   logic [63:0] sh_q[8];
`endif

   always_comb begin
      init_v[0] = ai;
      init_v[1] = bi;
      init_v[2] = ci;
      init_v[3] = di;
      init_v[4] = ei;
      init_v[5] = fi;
      init_v[6] = gi;
      init_v[7] = hi;
   end

   // Index 0..7 of v_q holds a..h.
   always_comb begin
      s1  = {v_q[4][13:0], v_q[4][63:14]} ^ {v_q[4][17:0], v_q[4][63:18]}
          ^ {v_q[4][40:0], v_q[4][63:41]};
      ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
      t1  = v_q[7] + s1 + ch + ki + wi;
      s0  = {v_q[0][27:0], v_q[0][63:28]} ^ {v_q[0][33:0], v_q[0][63:34]}
          ^ {v_q[0][38:0], v_q[0][63:39]};
      maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
      t2  = s0 + maj;
      rnd_d[0] = t1 + t2;
      rnd_d[1] = v_q[0];
      rnd_d[2] = v_q[1];
      rnd_d[3] = v_q[2];
      rnd_d[4] = v_q[3] + t1;
      rnd_d[5] = v_q[4];
      rnd_d[6] = v_q[5];
      rnd_d[7] = v_q[6];
      for (int i = 0; i < 8; i++) begin
`ifdef SHA512_FEEDFORWARD_EN
         fin_d[i] = rnd_d[i] + sh_q[i];
`else
         fin_d[i] = rnd_d[i];
`endif
      end
   end

   always_ff @(posedge clk or posedge sha512_reset) begin
      if (sha512_reset) begin
         state_q <= ST_LOAD;
         t_q     <= 7'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            v_q[i] <= 64'd0;
`ifdef SHA512_FEEDFORWARD_EN
            sh_q[i] <= 64'd0;
`endif
         end
      end else begin
         case (state_q)
            ST_LOAD: begin
               for (int i = 0; i < 8; i++) begin
                  v_q[i] <= init_v[i];
`ifdef SHA512_FEEDFORWARD_EN
                  sh_q[i] <= init_v[i];
`endif
               end
               t_q     <= 7'd0;
               state_q <= ST_ROUND;
            end
            ST_ROUND: begin
               t_q <= t_q + 7'd1;
               if (t_q == LAST_ROUND) begin
                  for (int i = 0; i < 8; i++) v_q[i] <= fin_d[i];
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  for (int i = 0; i < 8; i++) v_q[i] <= rnd_d[i];
               end
            end
            ST_DONE: begin
               // Hold everything; only reset leaves this state.
               done_q <= 1'b1;
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   assign oa          = v_q[0];
   assign ob          = v_q[1];
   assign oc          = v_q[2];
   assign od          = v_q[3];
   assign oe          = v_q[4];
   assign of          = v_q[5];
   assign og          = v_q[6];
   assign oh          = v_q[7];
   assign sha512_done = done_q;

endmodule

// File: tb/tb_sha512_compression.sv
// Bench for sha512_compression: random blocks against a plain-arithmetic SHA-512 round model.
// Handles both builds (SHA512_FEEDFORWARD_EN defined or not).
module tb_sha512_compression;

   localparam int ROUNDS = 80;

   logic        clk;
   logic        sha512_reset;
   logic [63:0] wi, ki;
   logic [63:0] ai, bi, ci, di, ei, fi, gi, hi;
   logic [63:0] oa, ob, oc, od, oe, of, og, oh;
   logic        sha512_done;

   int checks   = 0;
   int failures = 0;

   logic [511:0] exp_q[$];
   logic [63:0]  init_v[8];
   logic [63:0]  w_arr[ROUNDS];
   logic [63:0]  k_arr[ROUNDS];
   logic [511:0] snap[ROUNDS+1];
   logic [511:0] final_exp;
   logic [511:0] lit_r1;
   logic         done_seen;

   sha512_compression #(.ROUNDS(ROUNDS)) dut (
      .clk(clk), .sha512_reset(sha512_reset), .wi(wi), .ki(ki),
      .ai(ai), .bi(bi), .ci(ci), .di(di), .ei(ei), .fi(fi), .gi(gi), .hi(hi),
      .oa(oa), .ob(ob), .oc(oc), .od(od), .oe(oe), .of(of), .og(og), .oh(oh),
      .sha512_done(sha512_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] pack_out();
      return {oa, ob, oc, od, oe, of, og, oh};
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: SHA-512 round equations applied to a small array of words.
   task automatic model();
      logic [63:0] v[8];
      logic [63:0] s1, ch, t1, s0, mj, t2;
      logic [511:0] f;
      for (int i = 0; i < 8; i++) v[i] = init_v[i];
      snap[0] = {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
      for (int r = 0; r < ROUNDS; r++) begin
         s1 = rotr(v[4], 14) ^ rotr(v[4], 18) ^ rotr(v[4], 41);
         ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
         t1 = v[7] + s1 + ch + k_arr[r] + w_arr[r];
         s0 = rotr(v[0], 28) ^ rotr(v[0], 34) ^ rotr(v[0], 39);
         mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
         t2 = s0 + mj;
         v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
         v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
         snap[r+1] = {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
      end
`ifdef SHA512_FEEDFORWARD_EN
      for (int i = 0; i < 8; i++) v[i] = v[i] + init_v[i];
`endif
      f = {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
      final_exp = f;
   endtask

   // Runs one block from reset release; abort_at > 0 reasserts reset after that edge.
   task automatic run_block(input int abort_at, input bit lit_check);
      model();
      {ai, bi, ci, di, ei, fi, gi, hi} = {init_v[0], init_v[1], init_v[2], init_v[3],
                                         init_v[4], init_v[5], init_v[6], init_v[7]};
      if (abort_at <= 0) exp_q.push_back(final_exp);
      wi = rnd64();
      ki = rnd64();
      @(posedge clk); #1;
      sha512_reset = 1'b0;
      for (int e = 1; e <= ROUNDS + 1; e++) begin
         @(posedge clk); #1;
         if (e == 1) begin
            check("load_vals", pack_out(), snap[0]);
            check("load_done", {511'd0, sha512_done}, 512'd0);
         end
         if (e == 2) begin
            check("round1_vals", pack_out(), snap[1]);
            if (lit_check) check("round1_literal", pack_out(), lit_r1);
         end
         if (e == abort_at) begin
            #2;
            sha512_reset = 1'b1;
            #1;
            check("async_rst_vals", pack_out(), 512'd0);
            check("async_rst_done", {511'd0, sha512_done}, 512'd0);
            return;
         end
         if (e == ROUNDS)     check("done_early", {511'd0, sha512_done}, 512'd0);
         if (e == ROUNDS + 1) check("done_on_time", {511'd0, sha512_done}, {511'd0, 1'b1});
         if (e - 1 < ROUNDS) begin
            wi = w_arr[e-1];
            ki = k_arr[e-1];
         end
      end
      for (int e = 0; e < 20; e++) begin
         wi = rnd64();
         ki = rnd64();
         @(posedge clk); #1;
      end
      check("hold_vals", pack_out(), final_exp);
      check("hold_done", {511'd0, sha512_done}, {511'd0, 1'b1});
      sha512_reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: pops one expected result each time done rises.
   always @(negedge clk) begin
      if (sha512_reset || !sha512_done) begin
         done_seen = 1'b0;
      end else if (!done_seen) begin
         done_seen = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            check("result", pack_out(), exp_q.pop_front());
         end
      end
   end

   initial begin
      done_seen    = 1'b0;
      lit_r1       = {64'h001DC030C980001A, 64'd3, 64'd4, 64'd5,
                      64'h001DC0000380001B, 64'd7, 64'd8, 64'd9};
      sha512_reset = 1'b1;
      {ai, bi, ci, di, ei, fi, gi, hi} = {rnd64(), rnd64(), rnd64(), rnd64(),
                                         rnd64(), rnd64(), rnd64(), rnd64()};
      wi = rnd64();
      ki = rnd64();
      repeat (3) @(posedge clk);
      #1;
      check("reset_vals", pack_out(), 512'd0);
      check("reset_done", {511'd0, sha512_done}, 512'd0);

      // Known vector: a..h = 3..10, W=1, K=2 every round.
      for (int i = 0; i < 8; i++) init_v[i] = 64'(i + 3);
      for (int r = 0; r < ROUNDS; r++) begin
         w_arr[r] = 64'd1;
         k_arr[r] = 64'd2;
      end
      run_block(0, 1'b1);

      // Interrupted at round 40, then the same block from scratch.
      for (int i = 0; i < 8; i++) init_v[i] = rnd64();
      for (int r = 0; r < ROUNDS; r++) begin
         w_arr[r] = rnd64();
         k_arr[r] = rnd64();
      end
      run_block(41, 1'b0);
      run_block(0, 1'b0);

      for (int i = 0; i < 8; i++) init_v[i] = 64'd0;
      for (int r = 0; r < ROUNDS; r++) begin
         w_arr[r] = 64'd0;
         k_arr[r] = 64'd0;
      end
      run_block(0, 1'b0);

      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 8; i++) init_v[i] = rnd64();
         for (int r = 0; r < ROUNDS; r++) begin
            w_arr[r] = rnd64();
            k_arr[r] = rnd64();
         end
         run_block(0, 1'b0);
      end

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
